// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply, restoring divide,
// BITS_PER_CYCLE bits retired per CALC cycle, with a one-cycle fast path for divide corner cases.
module ex_muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                neg_q, neg_d;
    logic                fast_q, fast_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                accept, s1, s2, sgn_a, sgn_b, div0, ovf;
    logic [XLEN-1:0]     abs_a, abs_b, fast_val;

    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                   input logic [XLEN-1:0] a);
        logic [XLEN:0] s;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            s   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a} : {(XLEN+1){1'b0}});
            acc = {s, acc[XLEN-1:1]};
        end
        return acc;
    endfunction

    // Upper half holds the partial remainder, lower half shifts dividend out and quotient in.
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                   input logic [XLEN-1:0] b);
        logic [XLEN:0] rem;
        logic          q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem = acc[2*XLEN-1:XLEN-1];
            q   = (rem >= {1'b0, b});
            if (q) rem = rem - {1'b0, b};
            acc = {rem[XLEN-1:0], acc[XLEN-2:0], q};
        end
        return acc;
    endfunction

    function automatic logic [XLEN-1:0] finish_val(input logic [2:0] op, input logic [2*XLEN-1:0] acc,
                                                   input logic neg, input logic fast,
                                                   input logic [XLEN-1:0] fval);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   r;
        p = neg ? -acc : acc;
        r = '0;
        if (fast) begin
            r = fval;
        end else begin
            unique case (op)
                3'd0:             r = acc[XLEN-1:0];
                3'd1, 3'd2, 3'd3: r = p[2*XLEN-1:XLEN];
                3'd4, 3'd5:       r = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
                default:          r = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
            endcase
        end
        return r;
    endfunction

    assign accept = (state_q == IDLE) && start && !flush;
    assign s1     = rs1_val[XLEN-1];
    assign s2     = rs2_val[XLEN-1];
    assign sgn_a  = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign sgn_b  = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign abs_a  = (sgn_a && s1) ? -rs1_val : rs1_val;
    assign abs_b  = (sgn_b && s2) ? -rs2_val : rs2_val;
    assign div0   = funct3[2] && (rs2_val == '0);
    assign ovf    = funct3[2] && !funct3[0] && (rs1_val == MIN_VAL) && (rs2_val == '1);
    assign fast_val = div0 ? (funct3[1] ? rs1_val : '1) : (funct3[1] ? '0 : MIN_VAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            fast_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            fast_q   <= fast_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (div0 || ovf) ? DONE : CALC;
            CALC:    if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        fast_d   = fast_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (accept) begin
            op_d   = funct3;
            fast_d = div0 || ovf;
            a_d    = (div0 || ovf) ? fast_val : abs_a;
            b_d    = abs_b;
            acc_d  = funct3[2] ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
            neg_d  = ((funct3 == 3'd1) || (funct3 == 3'd4)) ? (s1 ^ s2) :
                     ((funct3 == 3'd2) || (funct3 == 3'd6)) ? s1 : 1'b0;
            cnt_d  = CW'(N);
        end
        if (state_q == CALC) begin
            acc_d = op_q[2] ? div_step(acc_q, b_q) : mul_step(acc_q, a_q);
            cnt_d = cnt_q - CW'(1);
        end
        if (done) result_d = result;
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE) && !flush;
        result = done ? finish_val(op_q, acc_q, neg_q, fast_q, a_q) : result_q;
    end

endmodule
